fifo_uart_framer: RTL

FIFO_UART_FRAMER -- requirements
Module: fifo_uart_framer

---
 rtl/fifo_uart_framer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_framer.sv
// Frames each 32-bit FIFO word as HEADER, four data bytes (MSB first) and an
// XOR checksum, handing bytes to a UART transmitter with a busy handshake.
module fifo_uart_framer #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk_50,
  input  logic        clr,
  input  logic        enable,
  input  logic [31:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_wr_en,
  output logic        frame_active,
  output logic [15:0] frame_count,
  output logic        timeout_err
);

  localparam int unsigned    TW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, LOAD, WAIT_BUSY, WAIT_DONE, NEXT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [2:0]     idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [7:0]     txd_q, txd_d;
  logic [15:0]    frame_count_q, frame_count_d;
  logic           err_q, err_d;
  logic [7:0]     cksum;
  logic [7:0]     sel_byte;

  always_comb begin
    cksum = word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
    case (idx_q)
      3'd0:    sel_byte = HEADER;
      3'd1:    sel_byte = word_q[31:24];
      3'd2:    sel_byte = word_q[23:16];
      3'd3:    sel_byte = word_q[15:8];
      3'd4:    sel_byte = word_q[7:0];
      3'd5:    sel_byte = cksum;
      default: sel_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      state_q       <= IDLE;
      word_q        <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      txd_q         <= '0;
      frame_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      txd_q         <= txd_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    txd_d         = txd_q;
    frame_count_d = frame_count_q;
    err_d         = err_q;
    case (state_q)
      IDLE:      if (enable && !fifo_empty && !tx_busy) state_d = READ;
      READ:      state_d = LATCH;
      LATCH: begin
        word_d  = fifo_q;
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        txd_d   = sel_byte;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          // Last count reaches ACK_TIMEOUT: give up on the ack and move on.
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = NEXT;
          end
        end
      end
      WAIT_DONE: if (!tx_busy) state_d = NEXT;
      NEXT: begin
        if (idx_q == 3'd5) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = LOAD;
        end
      end
      DONE: begin
        frame_count_d = frame_count_q + 16'd1;
        state_d       = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // tx_data shows the selected byte during LOAD itself, then holds it.
  always_comb begin
    fifo_rdreq   = (state_q == READ) && !fifo_empty;
    tx_wr_en     = (state_q == LOAD);
    tx_data      = (state_q == LOAD) ? sel_byte : txd_q;
    frame_active = (state_q != IDLE);
    frame_count  = frame_count_q;
    timeout_err  = err_q;
  end

endmodule
